// File: rtl/mult_bist_ctrl.sv
// BIST initiator for the signed Booth multiplier: LFSR operand generation,
// start/busy handshake per pattern, MISR compaction and golden compare.
module mult_bist_ctrl #(
    parameter int                   WIDTH        = 4,
    parameter int                   NUM_PATTERNS = 15,
    parameter logic [2*WIDTH-1:0]   LFSR_SEED    = 8'hA5,
    parameter logic [2*WIDTH-1:0]   LFSR_TAPS    = 8'hB8,
    parameter logic [2*WIDTH-1:0]   MISR_TAPS    = 8'hB8,
    parameter logic [2*WIDTH-1:0]   GOLDEN_SIG   = 8'h00,
    parameter int                   TIMEOUT      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    test,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    output logic                    mul_start,
    input  logic                    mul_busy,
    input  logic [2*WIDTH-1:0]      mul_product,
    output logic                    busy,
    output logic                    done,
    output logic                    pass
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [W2-1:0] SEED_EFF = (LFSR_SEED == '0) ? W2'(1) : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_LAUNCH, S_WAIT_HI, S_WAIT_LO, S_COMPACT, S_DONE
    } state_t;

    state_t          r_state, w_nxt;
    logic [W2-1:0]   r_lfsr, r_misr, r_prod;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_tflag;
    logic [WIDTH-1:0] r_mul_a, r_mul_b;
    logic            r_mul_start, r_busy, r_done, r_pass;

    logic [W2-1:0]   w_misr_nxt, w_misr_step, w_lfsr_step;
    logic            w_tflag_nxt, w_tmo_hit, w_last, w_abort;

    always_comb begin
        w_nxt       = r_state;
        w_misr_nxt  = r_misr;
        w_tflag_nxt = r_tflag;
        w_misr_step = {r_misr[W2-2:0], ^(r_misr & MISR_TAPS)} ^ r_prod;
        w_lfsr_step = {r_lfsr[W2-2:0], ^(r_lfsr & LFSR_TAPS)};
        w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
        w_last      = (r_cnt == CW'(NUM_PATTERNS - 1));
        w_abort     = !test && (r_state != S_IDLE) && (r_state != S_DONE);
        if (w_abort) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (test) w_nxt = S_SEED;
                S_SEED: begin
                    w_nxt       = S_LAUNCH;
                    w_misr_nxt  = '0;
                    w_tflag_nxt = 1'b0;
                end
                S_LAUNCH:  w_nxt = S_WAIT_HI;
                S_WAIT_HI: begin
                    if (mul_busy) begin
                        w_nxt = S_WAIT_LO;
                    end else if (w_tmo_hit) begin
                        w_nxt       = S_DONE;
                        w_tflag_nxt = 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!mul_busy) begin
                        w_nxt = S_COMPACT;
                    end else if (w_tmo_hit) begin
                        w_nxt       = S_DONE;
                        w_tflag_nxt = 1'b1;
                    end
                end
                S_COMPACT: begin
                    w_misr_nxt = w_misr_step;
                    w_nxt      = w_last ? S_DONE : S_LAUNCH;
                end
                S_DONE:    if (!test) w_nxt = S_IDLE;
                default:   w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // Status outputs are derived from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= '0;
            r_misr      <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_tflag     <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_misr      <= w_misr_nxt;
            r_tflag     <= w_tflag_nxt;
            r_mul_start <= (r_state == S_LAUNCH) && (w_nxt == S_WAIT_HI);
            r_busy      <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
            r_done      <= (w_nxt == S_DONE);
            r_pass      <= (w_nxt == S_DONE) && (w_misr_nxt == GOLDEN_SIG) && !w_tflag_nxt;
            case (r_state)
                S_SEED: begin
                    r_lfsr <= SEED_EFF;
                    r_cnt  <= '0;
                end
                S_LAUNCH: begin
                    r_mul_a <= r_lfsr[W2-1:WIDTH];
                    r_mul_b <= r_lfsr[WIDTH-1:0];
                    r_tmo   <= '0;
                end
                S_WAIT_HI: r_tmo <= mul_busy ? '0 : r_tmo + 1'b1;
                S_WAIT_LO: begin
                    if (!mul_busy) r_prod <= mul_product;
                    r_tmo <= r_tmo + 1'b1;
                end
                S_COMPACT: begin
                    r_lfsr <= w_lfsr_step;
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_start = r_mul_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;

endmodule
